// File: rtl/conv10bto32b_arb.sv
// Round-robin arbiter sharing one 10b->32b packer among N symbol lanes.
// Grants 16-symbol bursts so lanes switch on word boundaries; words are tagged with their lane id.

module conv10bto32b_arb_lane #(
  parameter int IDW  = 2,
  parameter int LANE = 0
) (
  input  logic           in_burst,
  input  logic [IDW-1:0] gnt,
  input  logic           vld,
  output logic           rdy,
  output logic           acc
);
  assign rdy = in_burst && (gnt == IDW'(LANE));
  assign acc = rdy & vld;
endmodule

module conv10bto32b_arb #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        i_req_vld,
  input  logic [N-1:0][9:0]   i_req_dat,
  output logic [N-1:0]        o_req_rdy,
  output logic                o_cnv_vld,
  output logic [9:0]          o_cnv_dat,
  input  logic                i_pkr_vld,
  output logic [IDW-1:0]      o_pkr_id,
  output logic                o_busy,
  output logic                o_err
);
  typedef enum logic {IDLE, BURST} state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] gnt, rr_ptr, pick;
  logic           found;
  logic [3:0]     beat;
  logic [2:0]     wcnt;
  logic [IDW-1:0] tag_mem [2];
  logic           rd_ptr, wr_ptr;
  logic [1:0]     occ;
  logic           push, pop;
  logic [N-1:0]   lane_acc;

  // Two passes: lanes at/after rr_ptr first, then wrap to the lowest lane.
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && i_req_vld[j] && (IDW'(j) >= rr_ptr)) begin
        pick  = IDW'(j);
        found = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && i_req_vld[j]) begin
        pick  = IDW'(j);
        found = 1'b1;
      end
    end
  end

  generate
    for (genvar k = 0; k < N; k++) begin : g_lane
      conv10bto32b_arb_lane #(.IDW(IDW), .LANE(k)) u_lane (
        .in_burst (state == BURST),
        .gnt      (gnt),
        .vld      (i_req_vld[k]),
        .rdy      (o_req_rdy[k]),
        .acc      (lane_acc[k])
      );
    end
  endgenerate

  assign o_cnv_vld = |lane_acc;
  assign o_cnv_dat = i_req_dat[gnt];

  // Fullness uses registered occupancy: a same-cycle pop does not free a slot.
  assign push = (state == IDLE) && found && (occ != 2'd2);
  assign pop  = i_pkr_vld && (occ != 2'd0) && (wcnt == 3'd4);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (push) state_nx = BURST;
      BURST:   if (o_cnv_vld && beat == 4'd15) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
      beat   <= '0;
      wcnt   <= '0;
      occ    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) begin
        gnt    <= pick;
        wr_ptr <= ~wr_ptr;
      end
      if (o_cnv_vld) begin
        beat <= beat + 4'd1;
        if (beat == 4'd15)
          rr_ptr <= (gnt == IDW'(N-1)) ? '0 : gnt + 1'b1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
      // A word with no tag pending is flagged and otherwise ignored.
      if (i_pkr_vld) begin
        if (occ == 2'd0) o_err <= 1'b1;
        else             wcnt  <= (wcnt == 3'd4) ? 3'd0 : wcnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= pick;
  end

  assign o_pkr_id = tag_mem[rd_ptr];
  assign o_busy   = (state == BURST) || (occ != 2'd0);
endmodule

// File: tb/tb_conv10bto32b_arb.sv
// Scoreboard bench: expected symbols/words queued at stimulus, a negedge monitor pops and compares.
module tb_conv10bto32b_arb;
  localparam int N = 4, IDW = 2;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]      i_req_vld;
  logic [N-1:0][9:0] i_req_dat;
  logic [N-1:0]      o_req_rdy;
  logic              o_cnv_vld;
  logic [9:0]        o_cnv_dat;
  logic              i_pkr_vld;
  logic [IDW-1:0]    o_pkr_id;
  logic              o_busy, o_err;
  logic              pk_vld, spur, stall;

  assign i_pkr_vld = pk_vld | spur;

  conv10bto32b_arb #(.N(N), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .i_req_vld(i_req_vld), .i_req_dat(i_req_dat),
    .o_req_rdy(o_req_rdy), .o_cnv_vld(o_cnv_vld), .o_cnv_dat(o_cnv_dat),
    .i_pkr_vld(i_pkr_vld), .o_pkr_id(o_pkr_id), .o_busy(o_busy), .o_err(o_err)
  );

  // Packer model: LSB-first bit stream, 32-bit words, optional output stall.
  logic [63:0] pacc;
  logic [5:0]  pnb;
  logic [31:0] wf [32];
  logic [4:0]  wp, rp;
  logic [31:0] pk_word;
  wire  [63:0] pacc_nx = pacc | (64'(o_cnv_dat) << pnb);

  always @(posedge clk) begin
    if (rst) begin
      pacc <= '0; pnb <= '0; wp <= '0; rp <= '0; pk_vld <= 1'b0; pk_word <= '0;
    end else begin
      if (o_cnv_vld) begin
        if (pnb >= 6'd22) begin
          wf[wp] <= pacc_nx[31:0];
          wp     <= wp + 5'd1;
          pacc   <= pacc_nx >> 32;
          pnb    <= pnb - 6'd22;
        end else begin
          pacc <= pacc_nx;
          pnb  <= pnb + 6'd10;
        end
      end
      pk_vld <= 1'b0;
      if (!stall && rp != wp) begin
        pk_vld  <= 1'b1;
        pk_word <= wf[rp];
        rp      <= rp + 5'd1;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [IDW-1:0] lane; logic [9:0] dat; } sym_t;
  typedef struct packed { logic [IDW-1:0] id; logic [31:0] w; } wrd_t;
  sym_t sq[$];
  wrd_t wq[$];

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_burst(input int lane, input logic [9:0] first);
    logic [159:0] bits;
    sym_t s;
    wrd_t w;
    bits = '0;
    for (int i = 0; i < 16; i++) begin
      s.lane = IDW'(lane);
      s.dat  = first + 10'(i);
      sq.push_back(s);
      bits[10*i +: 10] = s.dat;
    end
    for (int j = 0; j < 5; j++) begin
      w.id = IDW'(lane);
      w.w  = bits[32*j +: 32];
      wq.push_back(w);
    end
  endtask

  // Monitor
  int nwords, last_acc, bpos;
  bit b2b_en, have_prev, fw_got;
  logic [31:0] first_word;
  sym_t m_s;
  wrd_t m_w;
  int   m_ln;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (o_cnv_vld) begin
        m_ln = -1;
        for (int k = 0; k < N; k++) if (o_req_rdy[k]) m_ln = k;
        if (sq.size() == 0) begin
          checks++; errors++;
          $display("FAIL sym_unexpected: got lane %0d dat %0h with nothing expected", m_ln, o_cnv_dat);
        end else begin
          m_s = sq.pop_front();
          chk("sym_lane", m_ln, 32'(m_s.lane));
          chk("sym_dat", 32'(o_cnv_dat), 32'(m_s.dat));
        end
        if (b2b_en && bpos == 0 && have_prev) chk("b2b_gap", cyc - last_acc, 2);
        have_prev = 1'b1;
        last_acc  = cyc;
        bpos      = (bpos + 1) % 16;
      end
      if (pk_vld) begin
        nwords++;
        if (!fw_got) begin first_word = pk_word; fw_got = 1'b1; end
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL word_unexpected: got id %0d word %0h with nothing expected", o_pkr_id, pk_word);
        end else begin
          m_w = wq.pop_front();
          chk("word_id", 32'(o_pkr_id), 32'(m_w.id));
          chk("word_dat", pk_word, m_w.w);
        end
      end
    end
  end

  // Lane sources
  int          src_cnt [N], sent [N], gap_at [N], gap_left [N], rdy_cyc [N];
  logic [9:0]  src_nxt [N];
  int          early3, held1;

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      i_req_vld[k] = (src_cnt[k] > 0) && (gap_left[k] == 0);
      i_req_dat[k] = src_nxt[k];
    end
  endtask

  task automatic cycle();
    logic [N-1:0] a;
    @(negedge clk);
    a = i_req_vld & o_req_rdy;
    for (int k = 0; k < N; k++) if (o_req_rdy[k]) rdy_cyc[k]++;
    if (o_req_rdy[3] && sent[1] < 16) early3++;
    if (o_req_rdy[1] && !i_req_vld[1]) held1++;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (gap_left[k] > 0) gap_left[k]--;
      if (a[k]) begin
        src_cnt[k]--;
        src_nxt[k]++;
        sent[k]++;
        if (sent[k] == gap_at[k]) gap_left[k] = 3;
      end
    end
    drive();
  endtask

  task automatic load(input int k, input logic [9:0] first, input int n);
    src_cnt[k] = n; src_nxt[k] = first; sent[k] = 0; gap_at[k] = -1; gap_left[k] = 0;
    drive();
  endtask

  task automatic clear_stats();
    for (int k = 0; k < N; k++) rdy_cyc[k] = 0;
    early3 = 0; held1 = 0; bpos = 0; have_prev = 1'b0; nwords = 0; fw_got = 1'b0;
  endtask

  function automatic bit srcs_busy();
    for (int k = 0; k < N; k++) if (src_cnt[k] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle(input string nm, input int maxc);
    int n = 0;
    while ((srcs_busy() || o_busy || sq.size() != 0 || wq.size() != 0 || rp != wp) && n < maxc) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= maxc) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, queued sym %0d word %0d", nm, n, sq.size(), wq.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; spur = 1'b0;
    for (int k = 0; k < N; k++) src_cnt[k] = 0;
    drive();
    cycle(); cycle();
    sq.delete(); wq.delete();
    rst = 1'b0;
    clear_stats();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r2;
    for (int k = 0; k < N; k++) begin
      src_cnt[k] = 0; src_nxt[k] = '0; sent[k] = 0; gap_at[k] = -1; gap_left[k] = 0;
    end
    stall = 1'b0; spur = 1'b0; b2b_en = 1'b0;
    drive();
    @(posedge clk); #1;
    do_reset();

    chk("rst_rdy", 32'(o_req_rdy), 0);
    chk("rst_cnv_vld", 32'(o_cnv_vld), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_err", 32'(o_err), 0);

    // Single lane 2, symbols 0x001..0x010
    load(2, 10'h001, 16);
    exp_burst(2, 10'h001);
    cycle();
    chk("t1_grant_latency", 32'(o_req_rdy), 32'h4);
    wait_idle("t1", 200);
    chk("t1_rdy_cycles", rdy_cyc[2], 16);
    chk("t1_words", nwords, 5);
    chk("t1_word0", first_word, 32'h0030_0801);
    chk("t1_busy_end", 32'(o_busy), 0);

    // All four lanes from reset: order 0,1,2,3,0 with one bubble each
    do_reset();
    b2b_en = 1'b1;
    load(0, 10'h100, 32); load(1, 10'h200, 16); load(2, 10'h300, 16); load(3, 10'h3C0, 16);
    exp_burst(0, 10'h100); exp_burst(1, 10'h200); exp_burst(2, 10'h300);
    exp_burst(3, 10'h3C0); exp_burst(0, 10'h110);
    wait_idle("t2", 400);
    b2b_en = 1'b0;
    chk("t2_words", nwords, 25);

    // Lane 1 gaps for 3 cycles while lane 3 waits
    clear_stats();
    load(1, 10'h050, 16); gap_at[1] = 5;
    load(3, 10'h070, 16);
    exp_burst(1, 10'h050); exp_burst(3, 10'h070);
    wait_idle("t3", 200);
    chk("t3_lane3_early_rdy", early3, 0);
    chk("t3_lane1_held_gap", held1, 3);

    // Stalled packer: third burst waits for first tag pop
    clear_stats();
    stall = 1'b1;
    load(0, 10'h011, 16); load(1, 10'h022, 16); load(2, 10'h033, 16);
    exp_burst(0, 10'h011); exp_burst(1, 10'h022); exp_burst(2, 10'h033);
    n = 0;
    while (sent[1] < 16 && n < 200) begin cycle(); n++; end
    chk("t4_two_bursts_done", 32'(sent[1]), 16);
    r2 = 0;
    repeat (10) begin cycle(); if (o_req_rdy[2]) r2++; end
    chk("t4_no_grant_when_full", r2, 0);
    chk("t4_busy", 32'(o_busy), 1);
    chk("t4_head_id", 32'(o_pkr_id), 0);
    stall = 1'b0;
    n = 0;
    while (!o_req_rdy[2] && n < 50) begin cycle(); n++; end
    chk("t4_grant_after_pop", 32'((nwords >= 5) && (n < 50)), 1);
    wait_idle("t4", 300);

    // Reset at beat 7 of lane 2; next grant must start at lane 0
    clear_stats();
    load(2, 10'h155, 16);
    exp_burst(2, 10'h155);
    n = 0;
    while (sent[2] < 7 && n < 100) begin cycle(); n++; end
    rst = 1'b1;
    cycle();
    chk("t5_rdy", 32'(o_req_rdy), 0);
    chk("t5_cnv_vld", 32'(o_cnv_vld), 0);
    chk("t5_busy", 32'(o_busy), 0);
    chk("t5_err", 32'(o_err), 0);
    for (int k = 0; k < N; k++) src_cnt[k] = 0;
    drive();
    sq.delete(); wq.delete();
    rst = 1'b0;
    clear_stats();
    load(0, 10'h0A0, 16); load(2, 10'h0B0, 16); load(3, 10'h0C0, 16);
    exp_burst(0, 10'h0A0); exp_burst(2, 10'h0B0); exp_burst(3, 10'h0C0);
    wait_idle("t5", 300);

    // Spurious packer word with empty tag FIFO
    chk("t6_err_before", 32'(o_err), 0);
    spur = 1'b1;
    cycle();
    spur = 1'b0;
    chk("t6_err_rise", 32'(o_err), 1);
    clear_stats();
    load(1, 10'h3F0, 16);
    exp_burst(1, 10'h3F0);
    wait_idle("t6", 200);
    chk("t6_err_sticky", 32'(o_err), 1);
    chk("t6_words", nwords, 5);
    do_reset();
    chk("t6_err_cleared", 32'(o_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
